cmd_regbank: RTL and testbench

//  Parametrised command register bank; next generation of the ADC/DDS command decoder.

---
 rtl/cmd_regbank_pkg.sv | 23 ++
 rtl/cmd_regbank_pulse_stretch.sv | 17 +
 rtl/cmd_regbank.sv | 153 +++++++++++++++
 tb/tb_cmd_regbank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_regbank_pkg.sv
// cmd_regbank_pkg: address map, field widths and decode helper shared by the command register bank
package cmd_regbank_pkg;
  localparam int ADDR_ADC_RST = 'h00;
  localparam int ADDR_CHSEL   = 'h01;
  localparam int ADDR_DATANUM = 'h02;
  localparam int ADDR_SPEED   = 'h03;
  localparam int ADDR_CTRL    = 'h0D;
  localparam int ADDR_ERRCLR  = 'h0E;
  localparam int ADDR_COMMIT  = 'h0F;
  localparam int CH_BASE      = 'h10;
  localparam int CH_STRIDE    = 4;
  localparam int WAVE_W       = 3;
  localparam int PHASE_W      = 16;
  localparam int OFF_RST      = 0;
  localparam int OFF_WAVE     = 1;
  localparam int OFF_FTW      = 2;
  localparam int OFF_PHASE    = 3;

  function automatic logic addr_mapped(input int a, input int n);
    return a <= ADDR_SPEED || (a >= ADDR_CTRL && a <= ADDR_COMMIT) ||
           (a >= CH_BASE && a < CH_BASE + CH_STRIDE * n);
  endfunction
endpackage

// File: rtl/cmd_regbank_pulse_stretch.sv
// pulse_stretch: holds pulse_o high for PULSE_LEN cycles after trig; a retrigger reloads the count
module pulse_stretch #(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic pulse_o
);
  localparam int CW = $clog2(PULSE_LEN + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = trig ? CW'(PULSE_LEN) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign pulse_o = cnt_q != '0;
endmodule

// File: rtl/cmd_regbank.sv
// cmd_regbank: command-stream register bank for ADC config and double-buffered DDS channels,
// with readback and a sticky unmapped-address error flag
import cmd_regbank_pkg::*;
module cmd_regbank #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int CHSEL_W   = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmdvalid,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       cmd_ack,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       err_unmapped,
  output logic [CHSEL_W-1:0]         ChannelSel,
  output logic [DATA_W-1:0]          DataNum,
  output logic [DATA_W-1:0]          ADC_Speed_Set,
  output logic                       RestartReq,
  output logic [NUM_CH-1:0]          RestartReq_DDS,
  output logic [WAVE_W*NUM_CH-1:0]   DDS_WaveSel,
  output logic [DATA_W*NUM_CH-1:0]   DDS_FTW,
  output logic [PHASE_W*NUM_CH-1:0]  DDS_Phase
);
  logic [CHSEL_W-1:0] chsel_q, chsel_d;
  logic [DATA_W-1:0] num_q, num_d, speed_q, speed_d, rd_data_q, rd_data_d, rd_mux;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic ctrl_q, ctrl_d, err_q, err_d, ack_q, rdv_q, commit_w;
  logic [WAVE_W*NUM_CH-1:0] wave_stg_all;
  logic [DATA_W*NUM_CH-1:0] ftw_stg_all;
  logic [PHASE_W*NUM_CH-1:0] phase_stg_all;

  function automatic logic wr_at(input int a);
    return cmdvalid && cmd_addr == ADDR_W'(a);
  endfunction

  always_comb begin
    commit_w = wr_at(ADDR_COMMIT);
    chsel_d = wr_at(ADDR_CHSEL) ? cmd_data[CHSEL_W-1:0] : chsel_q;
    num_d = wr_at(ADDR_DATANUM) ? cmd_data : num_q;
    speed_d = wr_at(ADDR_SPEED) ? cmd_data : speed_q;
    ctrl_d = wr_at(ADDR_CTRL) ? cmd_data[0] : ctrl_q;
    mask_d = (commit_w && |cmd_data[NUM_CH-1:0]) ? cmd_data[NUM_CH-1:0] : mask_q;
    // a new error in the same cycle as a clear keeps the flag set
    err_d = (err_q && !wr_at(ADDR_ERRCLR)) ||
            (cmdvalid && !addr_mapped(32'(cmd_addr), NUM_CH)) ||
            (rd_req && !addr_mapped(32'(rd_addr), NUM_CH));
    rd_data_d = rd_req ? rd_mux : rd_data_q;
  end

  always_comb begin
    rd_mux = (rd_addr == ADDR_W'(ADDR_ADC_RST)) ? DATA_W'(RestartReq) :
             (rd_addr == ADDR_W'(ADDR_CHSEL))   ? DATA_W'(chsel_q) :
             (rd_addr == ADDR_W'(ADDR_DATANUM)) ? num_q :
             (rd_addr == ADDR_W'(ADDR_SPEED))   ? speed_q :
             (rd_addr == ADDR_W'(ADDR_CTRL))    ? DATA_W'(ctrl_q) :
             (rd_addr == ADDR_W'(ADDR_COMMIT))  ? DATA_W'(mask_q) : '0;
    for (int k = 0; k < NUM_CH; k++)
      if ((rd_addr >> 2) == ADDR_W'((CH_BASE + CH_STRIDE * k) >> 2))
        rd_mux = (rd_addr[1:0] == 2'(OFF_RST))  ? DATA_W'(RestartReq_DDS[k]) :
                 (rd_addr[1:0] == 2'(OFF_WAVE)) ? DATA_W'(wave_stg_all[WAVE_W*k +: WAVE_W]) :
                 (rd_addr[1:0] == 2'(OFF_FTW))  ? ftw_stg_all[DATA_W*k +: DATA_W] :
                 DATA_W'(phase_stg_all[PHASE_W*k +: PHASE_W]);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      chsel_q <= '1;
      num_q <= '0;
      speed_q <= '0;
      ctrl_q <= 1'b0;
      mask_q <= '0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      rdv_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      chsel_q <= chsel_d;
      num_q <= num_d;
      speed_q <= speed_d;
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      err_q <= err_d;
      ack_q <= cmdvalid;
      rdv_q <= rd_req;
      rd_data_q <= rd_data_d;
    end

  pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_adc_rst (
    .clk(clk), .reset(reset), .trig(wr_at(ADDR_ADC_RST)), .pulse_o(RestartReq)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int BASE = CH_BASE + CH_STRIDE * k;
    logic hit, hr, hw, hf, hp, commit;
    logic [WAVE_W-1:0] wave_stg_q, wave_stg_d, wave_act_q, wave_act_d;
    logic [DATA_W-1:0] ftw_stg_q, ftw_stg_d, ftw_act_q, ftw_act_d;
    logic [PHASE_W-1:0] ph_stg_q, ph_stg_d, ph_act_q, ph_act_d;
    always_comb begin
      hit = cmdvalid && (cmd_addr >> 2) == ADDR_W'(BASE >> 2);
      hr = hit && cmd_addr[1:0] == 2'(OFF_RST);
      hw = hit && cmd_addr[1:0] == 2'(OFF_WAVE);
      hf = hit && cmd_addr[1:0] == 2'(OFF_FTW);
      hp = hit && cmd_addr[1:0] == 2'(OFF_PHASE);
      commit = commit_w && cmd_data[k];
      wave_stg_d = hw ? cmd_data[WAVE_W-1:0] : wave_stg_q;
      ftw_stg_d = hf ? cmd_data : ftw_stg_q;
      ph_stg_d = hp ? cmd_data[PHASE_W-1:0] : ph_stg_q;
      wave_act_d = commit ? wave_stg_q : (ctrl_q && hw) ? cmd_data[WAVE_W-1:0] : wave_act_q;
      ftw_act_d = commit ? ftw_stg_q : (ctrl_q && hf) ? cmd_data : ftw_act_q;
      ph_act_d = commit ? ph_stg_q : (ctrl_q && hp) ? cmd_data[PHASE_W-1:0] : ph_act_q;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wave_stg_q <= '0;
        ftw_stg_q <= '0;
        ph_stg_q <= '0;
        wave_act_q <= '0;
        ftw_act_q <= '0;
        ph_act_q <= '0;
      end else begin
        wave_stg_q <= wave_stg_d;
        ftw_stg_q <= ftw_stg_d;
        ph_stg_q <= ph_stg_d;
        wave_act_q <= wave_act_d;
        ftw_act_q <= ftw_act_d;
        ph_act_q <= ph_act_d;
      end
    pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_dds_rst (
      .clk(clk), .reset(reset), .trig(hr || commit), .pulse_o(RestartReq_DDS[k])
    );
    assign DDS_WaveSel[WAVE_W*k +: WAVE_W] = wave_act_q;
    assign DDS_FTW[DATA_W*k +: DATA_W] = ftw_act_q;
    assign DDS_Phase[PHASE_W*k +: PHASE_W] = ph_act_q;
    assign wave_stg_all[WAVE_W*k +: WAVE_W] = wave_stg_q;
    assign ftw_stg_all[DATA_W*k +: DATA_W] = ftw_stg_q;
    assign phase_stg_all[PHASE_W*k +: PHASE_W] = ph_stg_q;
  end

  assign cmd_ack = ack_q;
  assign rd_valid = rdv_q;
  assign rd_data = rd_data_q;
  assign err_unmapped = err_q;
  assign ChannelSel = chsel_q;
  assign DataNum = num_q;
  assign ADC_Speed_Set = speed_q;
endmodule

// File: tb/tb_cmd_regbank.sv
// tb_cmd_regbank: directed stimulus against a cycle-count register-map model, plus literal checks
module tb_cmd_regbank;
  localparam int NCH = 2;
  localparam int PL = 4;
  logic clk = 0, reset = 1, cmdvalid = 0, rd_req = 0;
  logic [7:0] cmd_addr = 0, rd_addr = 0;
  logic [31:0] cmd_data = 0;
  logic cmd_ack, rd_valid, err_unmapped, RestartReq;
  logic [31:0] rd_data, DataNum, ADC_Speed_Set;
  logic [7:0] ChannelSel;
  logic [NCH-1:0] RestartReq_DDS;
  logic [3*NCH-1:0] DDS_WaveSel;
  logic [32*NCH-1:0] DDS_FTW;
  logic [16*NCH-1:0] DDS_Phase;
  int checks = 0, failures = 0;
  bit run = 0;

  cmd_regbank #(.ADDR_W(8), .DATA_W(32), .NUM_CH(NCH), .CHSEL_W(8), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset(reset), .cmdvalid(cmdvalid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .err_unmapped(err_unmapped), .ChannelSel(ChannelSel), .DataNum(DataNum),
    .ADC_Speed_Set(ADC_Speed_Set), .RestartReq(RestartReq), .RestartReq_DDS(RestartReq_DDS),
    .DDS_WaveSel(DDS_WaveSel), .DDS_FTW(DDS_FTW), .DDS_Phase(DDS_Phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // model: register values as plain arrays, pulses as "high until cycle N"
  int cyc, adc_until, dds_until [NCH];
  logic [7:0] m_chsel;
  logic [31:0] m_num, m_speed, m_rd, stg_f [NCH], act_f [NCH];
  logic [2:0] stg_w [NCH], act_w [NCH];
  logic [15:0] stg_p [NCH], act_p [NCH];
  logic [NCH-1:0] m_mask;
  logic m_ctrl, m_err, m_ack, m_rdv;

  function automatic logic [31:0] mread(input int a, output bit unm);
    int k;
    unm = 0;
    if (a == 0) return {31'b0, cyc < adc_until};
    if (a == 1) return {24'b0, m_chsel};
    if (a == 2) return m_num;
    if (a == 3) return m_speed;
    if (a == 13) return {31'b0, m_ctrl};
    if (a == 14) return 0;
    if (a == 15) return {{(32-NCH){1'b0}}, m_mask};
    if (a >= 16 && a < 16 + 4 * NCH) begin
      k = (a - 16) / 4;
      if (a % 4 == 0) return {31'b0, cyc < dds_until[k]};
      if (a % 4 == 1) return {29'b0, stg_w[k]};
      if (a % 4 == 2) return stg_f[k];
      return {16'b0, stg_p[k]};
    end
    unm = 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit ru, wu, clr;
    int a, k;
    if (reset) begin
      cyc = 0; adc_until = 0; m_chsel = 8'hFF; m_num = 0; m_speed = 0; m_rd = 0;
      m_mask = 0; m_ctrl = 0; m_err = 0; m_ack = 0; m_rdv = 0;
      for (int i = 0; i < NCH; i++) begin
        dds_until[i] = 0; stg_f[i] = 0; act_f[i] = 0; stg_w[i] = 0; act_w[i] = 0;
        stg_p[i] = 0; act_p[i] = 0;
      end
    end else begin
      ru = 0; wu = 0; clr = 0;
      if (rd_req) m_rd = mread(int'(rd_addr), ru);
      m_rdv = rd_req;
      m_ack = cmdvalid;
      cyc++;
      if (cmdvalid) begin
        a = int'(cmd_addr);
        if (a == 0) adc_until = cyc + PL;
        else if (a == 1) m_chsel = cmd_data[7:0];
        else if (a == 2) m_num = cmd_data;
        else if (a == 3) m_speed = cmd_data;
        else if (a == 13) m_ctrl = cmd_data[0];
        else if (a == 14) clr = 1;
        else if (a == 15) begin
          for (int i = 0; i < NCH; i++)
            if (cmd_data[i]) begin
              act_w[i] = stg_w[i]; act_f[i] = stg_f[i]; act_p[i] = stg_p[i];
              dds_until[i] = cyc + PL;
            end
          if (cmd_data[NCH-1:0] != 0) m_mask = cmd_data[NCH-1:0];
        end else if (a >= 16 && a < 16 + 4 * NCH) begin
          k = (a - 16) / 4;
          case (a % 4)
            0: dds_until[k] = cyc + PL;
            1: begin stg_w[k] = cmd_data[2:0]; if (m_ctrl) act_w[k] = cmd_data[2:0]; end
            2: begin stg_f[k] = cmd_data; if (m_ctrl) act_f[k] = cmd_data; end
            default: begin stg_p[k] = cmd_data[15:0]; if (m_ctrl) act_p[k] = cmd_data[15:0]; end
          endcase
        end else wu = 1;
      end
      m_err = (m_err && !clr) || wu || ru;
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] er;
    logic [3*NCH-1:0] ew;
    logic [32*NCH-1:0] ef;
    logic [16*NCH-1:0] ep;
    if (run && !reset) begin
      for (int i = 0; i < NCH; i++) begin
        er[i] = cyc < dds_until[i];
        ew[3*i +: 3] = act_w[i];
        ef[32*i +: 32] = act_f[i];
        ep[16*i +: 16] = act_p[i];
      end
      chk("m_ack", cmd_ack, m_ack);
      chk("m_rdv", rd_valid, m_rdv);
      chk("m_rd", rd_data, m_rd);
      chk("m_err", err_unmapped, m_err);
      chk("m_chsel", ChannelSel, m_chsel);
      chk("m_num", DataNum, m_num);
      chk("m_speed", ADC_Speed_Set, m_speed);
      chk("m_adcrst", RestartReq, cyc < adc_until);
      chk("m_ddsrst", RestartReq_DDS, er);
      chk("m_wave", DDS_WaveSel, ew);
      chk("m_ftw", DDS_FTW, ef);
      chk("m_phase", DDS_Phase, ep);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cmdvalid = 1; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmdvalid = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_req = 1; rd_addr = a;
    @(negedge clk);
    rd_req = 0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 0;
    run = 1;
    chk("rst_chsel", ChannelSel, 8'hFF);
    chk("rst_ftw", DDS_FTW, 0);
    chk("rst_num", DataNum, 0);
    chk("rst_err", err_unmapped, 0);
    // 1: ChannelSel write and single-cycle ack
    wr(8'h01, 32'h5A);
    chk("chsel_5a", ChannelSel, 8'h5A);
    chk("ack_hi", cmd_ack, 1);
    @(negedge clk);
    chk("ack_lo", cmd_ack, 0);
    // 2: staged FTW, readback, commit
    wr(8'h12, 32'h1234_5678);
    chk("ftw_staged_only", DDS_FTW[31:0], 0);
    rd(8'h12);
    chk("rd_stg_ftw", rd_data, 32'h1234_5678);
    chk("rd_valid", rd_valid, 1);
    wr(8'h0F, 32'h1);
    chk("ftw_commit", DDS_FTW[31:0], 32'h1234_5678);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += (RestartReq_DDS == 2'b01) ? 1 : 0;
      @(negedge clk);
    end
    chk("dds_pulse_len", n, 4);
    chk("dds_pulse_end", RestartReq_DDS, 0);
    // 3: retriggered ADC restart stays high t+1..t+6
    wr(8'h00, 0);
    n = int'(RestartReq);
    @(negedge clk);
    n += int'(RestartReq);
    wr(8'h00, 0);
    n += int'(RestartReq);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n += int'(RestartReq);
    end
    chk("adc_retrig_len", n, 6);
    @(negedge clk);
    chk("adc_retrig_end", RestartReq, 0);
    // 4: auto-commit, no DDS pulse
    wr(8'h0D, 1);
    wr(8'h15, 3);
    chk("auto_wave", DDS_WaveSel[5:3], 3);
    chk("auto_nopulse", RestartReq_DDS, 0);
    wr(8'h0D, 0);
    // same-cycle read and write returns the old value
    wr(8'h02, 32'h11);
    cmdvalid = 1; cmd_addr = 8'h02; cmd_data = 32'h22; rd_req = 1; rd_addr = 8'h02;
    @(negedge clk);
    cmdvalid = 0; rd_req = 0;
    chk("rw_old", rd_data, 32'h11);
    chk("rw_new", DataNum, 32'h22);
    // 5: unmapped write/read and clear
    wr(8'h18, 32'hDEAD);
    chk("unm_wr", err_unmapped, 1);
    wr(8'h0E, 0);
    chk("err_clr", err_unmapped, 0);
    rd(8'h7F);
    chk("unm_rd_data", rd_data, 0);
    chk("unm_rd_err", err_unmapped, 1);
    cmdvalid = 1; cmd_addr = 8'h0E; rd_req = 1; rd_addr = 8'h40;
    @(negedge clk);
    cmdvalid = 0; rd_req = 0;
    chk("set_wins", err_unmapped, 1);
    wr(8'h0E, 0);
    wr(8'h0F, 0);
    chk("commit0_nopulse", RestartReq_DDS, 0);
    rd(8'h0F);
    chk("rd_mask", rd_data, 1);
    // 6: reset during an active DDS pulse
    wr(8'h16, 32'hCAFE_BABE);
    wr(8'h0F, 32'h2);
    chk("ch1_commit", DDS_FTW[63:32], 32'hCAFE_BABE);
    chk("ch1_pulse", RestartReq_DDS, 2'b10);
    #3 reset = 1;
    #1;
    chk("arst_pulse", RestartReq_DDS, 0);
    chk("arst_ftw", DDS_FTW, 0);
    chk("arst_chsel", ChannelSel, 8'hFF);
    @(negedge clk);
    reset = 0;
    rd(8'h16);
    chk("arst_stg", rd_data, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
